// File: rtl/dcache_flush_walker_if.sv
// Handshake bundle between the D-cache flush walker and the cache datapath.
// master: the walker (drives requests, index/way, writeback address, status).
// slave:  the tag array / writeback port / requester side.
// Signals:
//   flush_i, busy_o, flush_ack_o            - walk request and status
//   tag_req_o/gnt_i/rvalid_i, tag_valid_i,
//   tag_dirty_i, tag_i, idx_o, way_o        - tag-array read channel
//   wb_req_o/gnt_i/done_i, wb_addr_o        - writeback channel
//   clr_req_o/gnt_i, clr_valid_o            - state-bit clear channel
//   wb_count_o                              - dirty lines written back by the last walk
interface dcache_flush_walker_if #(
    parameter int unsigned IdxW = 8,
    parameter int unsigned WayW = 3,
    parameter int unsigned TagW = 44,
    parameter int unsigned Plen = 56
);
    logic            flush_i;
    logic            busy_o;
    logic            flush_ack_o;
    logic            tag_req_o;
    logic            tag_gnt_i;
    logic            tag_rvalid_i;
    logic            tag_valid_i;
    logic            tag_dirty_i;
    logic [TagW-1:0] tag_i;
    logic [IdxW-1:0] idx_o;
    logic [WayW-1:0] way_o;
    logic            wb_req_o;
    logic            wb_gnt_i;
    logic            wb_done_i;
    logic [Plen-1:0] wb_addr_o;
    logic            clr_req_o;
    logic            clr_gnt_i;
    logic            clr_valid_o;
    logic [15:0]     wb_count_o;

    modport master (
        input  flush_i, tag_gnt_i, tag_rvalid_i, tag_valid_i, tag_dirty_i, tag_i,
               wb_gnt_i, wb_done_i, clr_gnt_i,
        output busy_o, flush_ack_o, tag_req_o, idx_o, way_o, wb_req_o, wb_addr_o,
               clr_req_o, clr_valid_o, wb_count_o
    );

    modport slave (
        output flush_i, tag_gnt_i, tag_rvalid_i, tag_valid_i, tag_dirty_i, tag_i,
               wb_gnt_i, wb_done_i, clr_gnt_i,
        input  busy_o, flush_ack_o, tag_req_o, idx_o, way_o, wb_req_o, wb_addr_o,
               clr_req_o, clr_valid_o, wb_count_o
    );
endinterface

// File: rtl/dcache_flush_walker.sv
// Sequential D-cache flush engine. On a flush request it visits every (index, way)
// pair in order (way fastest), reads the tag, writes back valid+dirty lines, clears
// the state bits of written-back lines (and of clean valid lines when the cache
// invalidates on flush), then pulses flush_ack_o for one cycle.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   bus     - dcache_flush_walker_if.master (request, tag, writeback, clear channels)
// All outputs are registered; at most one of the three request lines is ever high.
module dcache_flush_walker #(
    parameter int unsigned NumWords          = 256,
    parameter int unsigned SetAssoc          = 8,
    parameter int unsigned TagWidth          = 44,
    parameter int unsigned OffsetWidth       = 4,
    parameter int unsigned Plen              = 56,
    parameter bit          InvalidateOnFlush = 1'b1,
    // Ceiling of the writeback counter; full 16-bit range by default.
    parameter logic [15:0] WbCountMax        = 16'hFFFF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    dcache_flush_walker_if.master  bus
);
    localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned WayW = (SetAssoc > 1) ? $clog2(SetAssoc) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);
    localparam logic [WayW-1:0] LastWay = WayW'(SetAssoc - 1);

    typedef enum logic [2:0] {
        StIdle, StTagReq, StTagWait, StWbReq, StWbWait, StClrReq, StNext, StDone
    } state_e;

    state_e                r_state;
    logic [IdxW-1:0]       r_idx;
    logic [WayW-1:0]       r_way;
    logic [TagWidth-1:0]   r_tag;
    logic [15:0]           r_walk_cnt;
    logic [15:0]           r_wb_count;
    logic                  r_busy;
    logic                  r_ack;
    logic                  r_tag_req;
    logic                  r_wb_req;
    logic                  r_clr_req;
    logic [15:0]           w_cnt_inc;

    assign w_cnt_inc = (r_walk_cnt == WbCountMax) ? r_walk_cnt : r_walk_cnt + 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_way      <= '0;
            r_tag      <= '0;
            r_walk_cnt <= '0;
            r_wb_count <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_tag_req  <= 1'b0;
            r_wb_req   <= 1'b0;
            r_clr_req  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.flush_i) begin
                        r_idx      <= '0;
                        r_way      <= '0;
                        r_walk_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_tag_req  <= 1'b1;
                        r_state    <= StTagReq;
                    end
                end
                StTagReq: begin
                    if (bus.tag_gnt_i) begin
                        r_tag_req <= 1'b0;
                        r_state   <= StTagWait;
                    end
                end
                StTagWait: begin
                    if (bus.tag_rvalid_i) begin
                        r_tag <= bus.tag_i;
                        if (bus.tag_valid_i && bus.tag_dirty_i) begin
                            r_wb_req <= 1'b1;
                            r_state  <= StWbReq;
                        end else if (bus.tag_valid_i && InvalidateOnFlush) begin
                            r_clr_req <= 1'b1;
                            r_state   <= StClrReq;
                        end else begin
                            r_state <= StNext;
                        end
                    end
                end
                StWbReq: begin
                    if (bus.wb_gnt_i) begin
                        r_wb_req <= 1'b0;
                        // Completion may coincide with the grant.
                        if (bus.wb_done_i) begin
                            r_walk_cnt <= w_cnt_inc;
                            r_clr_req  <= 1'b1;
                            r_state    <= StClrReq;
                        end else begin
                            r_state <= StWbWait;
                        end
                    end
                end
                StWbWait: begin
                    if (bus.wb_done_i) begin
                        r_walk_cnt <= w_cnt_inc;
                        r_clr_req  <= 1'b1;
                        r_state    <= StClrReq;
                    end
                end
                StClrReq: begin
                    if (bus.clr_gnt_i) begin
                        r_clr_req <= 1'b0;
                        r_state   <= StNext;
                    end
                end
                StNext: begin
                    if (r_way == LastWay) begin
                        r_way <= '0;
                        if (r_idx == LastIdx) begin
                            r_ack      <= 1'b1;
                            r_wb_count <= r_walk_cnt;
                            r_state    <= StDone;
                        end else begin
                            r_idx     <= r_idx + IdxW'(1);
                            r_tag_req <= 1'b1;
                            r_state   <= StTagReq;
                        end
                    end else begin
                        r_way     <= r_way + WayW'(1);
                        r_tag_req <= 1'b1;
                        r_state   <= StTagReq;
                    end
                end
                StDone: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy_o      = r_busy;
    assign bus.flush_ack_o = r_ack;
    assign bus.tag_req_o   = r_tag_req;
    assign bus.idx_o       = r_idx;
    assign bus.way_o       = r_way;
    assign bus.wb_req_o    = r_wb_req;
    assign bus.wb_addr_o   = Plen'({r_tag, r_idx, {OffsetWidth{1'b0}}});
    assign bus.clr_req_o   = r_clr_req;
    assign bus.clr_valid_o = InvalidateOnFlush;
    assign bus.wb_count_o  = r_wb_count;
endmodule

// File: tb/tb_dcache_flush_walker.sv
module tb_dcache_flush_walker;
    localparam int NW = 256, NA = 8, IW = 8, AW = 3, TW = 44, OW = 4, PL = 56;
    localparam int NL = NW * NA;
    localparam int SNW = 4, SNA = 2, SIW = 2, SAW = 1, STW = 10, SPL = 16;
    localparam int Budget = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_flush_walker_if #(.IdxW(IW), .WayW(AW), .TagW(TW), .Plen(PL)) bus ();
    dcache_flush_walker_if #(.IdxW(SIW), .WayW(SAW), .TagW(STW), .Plen(SPL)) sbus ();

    dcache_flush_walker #(
        .NumWords(NW), .SetAssoc(NA), .TagWidth(TW), .OffsetWidth(OW), .Plen(PL),
        .InvalidateOnFlush(1'b1), .WbCountMax(16'hFFFF)
    ) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    dcache_flush_walker #(
        .NumWords(SNW), .SetAssoc(SNA), .TagWidth(STW), .OffsetWidth(OW), .Plen(SPL),
        .InvalidateOnFlush(1'b0), .WbCountMax(16'd5)
    ) dut_small (.clk_i(clk), .rst_ni(rst_n), .bus(sbus));

    int n_vec = 0;
    int n_err = 0;

    // Cache contents model and expected walk results.
    bit            m_valid [NW][NA];
    bit            m_dirty [NW][NA];
    logic [TW-1:0] m_tag   [NW][NA];
    logic [PL-1:0] exp_wb[$];
    int            exp_clr[$];
    int            exp_count;

    // Observed handshakes.
    int            tag_log[$];
    int            clr_log[$];
    logic [PL-1:0] wb_log[$];
    int ack_cnt = 0, onehot_viol = 0, stable_viol = 0, clrv_viol = 0, wb_req_cycles = 0;
    int gnt_stall = 0, done_dly = 0, stall_left = 0, done_left = 0;
    bit wb_busy = 1'b0, rv_pend = 1'b0, wb_hold_v = 1'b0;
    int rv_idx = 0, rv_way = 0;
    logic [PL-1:0] wb_hold;

    // Cache-side responder for the main instance: driven on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.tag_gnt_i = 1'b0; bus.tag_rvalid_i = 1'b0; bus.tag_valid_i = 1'b0;
            bus.tag_dirty_i = 1'b0; bus.tag_i = '0; bus.wb_gnt_i = 1'b0;
            bus.wb_done_i = 1'b0; bus.clr_gnt_i = 1'b0;
            rv_pend = 1'b0; wb_busy = 1'b0; wb_hold_v = 1'b0; stall_left = gnt_stall;
        end else begin
            bus.tag_rvalid_i = rv_pend;
            if (rv_pend) begin
                bus.tag_valid_i = m_valid[rv_idx][rv_way];
                bus.tag_dirty_i = m_dirty[rv_idx][rv_way];
                bus.tag_i       = m_tag[rv_idx][rv_way];
            end else begin
                bus.tag_valid_i = 1'($urandom);
                bus.tag_dirty_i = 1'($urandom);
                bus.tag_i       = TW'({$urandom, $urandom});
            end
            rv_pend = 1'b0;
            bus.tag_gnt_i = bus.tag_req_o;
            if (bus.tag_req_o) begin
                rv_idx = int'(bus.idx_o);
                rv_way = int'(bus.way_o);
                tag_log.push_back(rv_idx * NA + rv_way);
                rv_pend = 1'b1;
            end
            bus.wb_gnt_i = 1'b0;
            bus.wb_done_i = 1'b0;
            if (wb_busy) begin
                done_left--;
                if (done_left <= 0) begin
                    bus.wb_done_i = 1'b1; wb_busy = 1'b0; stall_left = gnt_stall;
                end
            end else if (bus.wb_req_o) begin
                wb_req_cycles++;
                if (wb_hold_v && bus.wb_addr_o !== wb_hold) stable_viol++;
                wb_hold = bus.wb_addr_o;
                wb_hold_v = 1'b1;
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    bus.wb_gnt_i = 1'b1;
                    wb_log.push_back(bus.wb_addr_o);
                    wb_hold_v = 1'b0;
                    if (done_dly == 0) begin
                        bus.wb_done_i = 1'b1; stall_left = gnt_stall;
                    end else begin
                        wb_busy = 1'b1; done_left = done_dly;
                    end
                end
            end
            bus.clr_gnt_i = bus.clr_req_o;
            if (bus.clr_req_o) begin
                clr_log.push_back(int'(bus.idx_o) * NA + int'(bus.way_o));
                if (bus.clr_valid_o !== 1'b1) clrv_viol++;
            end
            if ((int'(bus.tag_req_o) + int'(bus.wb_req_o) + int'(bus.clr_req_o)) > 1)
                onehot_viol++;
            if (bus.flush_ack_o) ack_cnt++;
        end
    end

    // Responder for the small instance: always-grant, writeback done with the grant.
    bit s_valid [SNW][SNA];
    bit s_dirty [SNW][SNA];
    int s_tag_cnt = 0, s_wb_cnt = 0, s_clr_cnt = 0, s_ack_cnt = 0, s_order_err = 0;
    bit s_pend = 1'b0;
    int s_idx = 0, s_way = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbus.tag_gnt_i = 1'b0; sbus.tag_rvalid_i = 1'b0; sbus.tag_valid_i = 1'b0;
            sbus.tag_dirty_i = 1'b0; sbus.tag_i = '0; sbus.wb_gnt_i = 1'b0;
            sbus.wb_done_i = 1'b0; sbus.clr_gnt_i = 1'b0; s_pend = 1'b0;
        end else begin
            sbus.tag_rvalid_i = s_pend;
            sbus.tag_valid_i  = s_pend ? s_valid[s_idx][s_way] : 1'b0;
            sbus.tag_dirty_i  = s_pend ? s_dirty[s_idx][s_way] : 1'b0;
            sbus.tag_i        = STW'($urandom);
            s_pend = 1'b0;
            sbus.tag_gnt_i = sbus.tag_req_o;
            if (sbus.tag_req_o) begin
                s_idx = int'(sbus.idx_o);
                s_way = int'(sbus.way_o);
                if (s_idx * SNA + s_way != s_tag_cnt) s_order_err++;
                s_tag_cnt++;
                s_pend = 1'b1;
            end
            sbus.wb_gnt_i  = sbus.wb_req_o;
            sbus.wb_done_i = sbus.wb_req_o;
            if (sbus.wb_req_o) s_wb_cnt++;
            sbus.clr_gnt_i = sbus.clr_req_o;
            if (sbus.clr_req_o) s_clr_cnt++;
            if (sbus.flush_ack_o) s_ack_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tag_log.delete(); clr_log.delete(); wb_log.delete();
        ack_cnt = 0; onehot_viol = 0; stable_viol = 0; clrv_viol = 0; wb_req_cycles = 0;
        stall_left = gnt_stall;
    endtask

    // 0: all invalid (random dirty bits), 1: valid clean, 2: valid dirty, else random.
    task automatic fill(input int mode);
        for (int i = 0; i < NW; i++) begin
            for (int w = 0; w < NA; w++) begin
                case (mode)
                    0: begin m_valid[i][w] = 1'b0; m_dirty[i][w] = 1'($urandom); end
                    1: begin m_valid[i][w] = 1'b1; m_dirty[i][w] = 1'b0; end
                    2: begin m_valid[i][w] = 1'b1; m_dirty[i][w] = 1'b1; end
                    default: begin
                        m_valid[i][w] = 1'($urandom); m_dirty[i][w] = 1'($urandom);
                    end
                endcase
                m_tag[i][w] = TW'({$urandom, $urandom});
            end
        end
    endtask

    // Expected effects of one walk, straight from the line state.
    task automatic build_expected();
        exp_wb.delete(); exp_clr.delete(); exp_count = 0;
        for (int i = 0; i < NW; i++) begin
            for (int w = 0; w < NA; w++) begin
                if (m_valid[i][w] && m_dirty[i][w]) begin
                    exp_wb.push_back(PL'({m_tag[i][w], IW'(i), OW'(0)}));
                    exp_clr.push_back(i * NA + w);
                    exp_count++;
                end else if (m_valid[i][w]) begin
                    exp_clr.push_back(i * NA + w);
                end
            end
        end
        if (exp_count > 65535) exp_count = 65535;
    endtask

    task automatic run_walk();
        clear_logs();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int c = 0; c < Budget && ack_cnt == 0; c++) tick();
        if (ack_cnt == 0) begin
            n_vec++; n_err++;
            $display("FAIL walk_timeout: got no flush_ack_o in %0d cycles, required 1", Budget);
        end
        tick();
    endtask

    function automatic int order_errs();
        int bad = 0;
        foreach (tag_log[k]) if (tag_log[k] != k) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; bus.flush_i = 1'b0; sbus.flush_i = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({bus.busy_o, bus.flush_ack_o, bus.tag_req_o, bus.wb_req_o, bus.clr_req_o} !== 5'b0)
        begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 00000", {bus.busy_o, bus.flush_ack_o,
                     bus.tag_req_o, bus.wb_req_o, bus.clr_req_o});
        end
        n_vec++;
        if ({bus.idx_o, bus.way_o, bus.wb_count_o} !== '0) begin
            n_err++;
            $display("FAIL reset_pos: idx %h way %h count %h, required 0", bus.idx_o, bus.way_o,
                     bus.wb_count_o);
        end
        n_vec++;
        if (bus.wb_addr_o !== '0 || bus.clr_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_addr: addr %h clr_valid %b, required 0 and 1", bus.wb_addr_o,
                     bus.clr_valid_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_empty();
        fill(0);
        run_walk();
        n_vec++;
        if (tag_log.size() != NL || order_errs() != 0) begin
            n_err++;
            $display("FAIL empty_tags: got %0d reads (%0d out of order), required %0d in order",
                     tag_log.size(), order_errs(), NL);
        end
        n_vec++;
        if (wb_log.size() != 0 || clr_log.size() != 0) begin
            n_err++;
            $display("FAIL empty_wb_clr: got %0d wb %0d clr, required 0 0", wb_log.size(),
                     clr_log.size());
        end
        n_vec++;
        if (ack_cnt != 1 || bus.wb_count_o !== 16'd0 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL empty_done: acks %0d count %0d busy %b, required 1 0 0", ack_cnt,
                     bus.wb_count_o, bus.busy_o);
        end
    endtask

    task automatic test_single_dirty();
        logic [PL-1:0] got;
        fill(0);
        m_valid[8'h5A][3] = 1'b1; m_dirty[8'h5A][3] = 1'b1; m_tag[8'h5A][3] = TW'(44'hABC);
        run_walk();
        got = (wb_log.size() == 1) ? wb_log[0] : '1;
        n_vec++;
        if (wb_log.size() != 1 || got !== 56'h0000ABC5A0) begin
            n_err++;
            $display("FAIL single_wb: got %0d wb addr %h, required 1 at 0000abc5a0",
                     wb_log.size(), got);
        end
        n_vec++;
        if (clr_log.size() != 1 || (clr_log.size() == 1 && clr_log[0] != 8'h5A * NA + 3)) begin
            n_err++;
            $display("FAIL single_clr: got %0d clears, required 1 at idx 5a way 3",
                     clr_log.size());
        end
        n_vec++;
        if (bus.wb_count_o !== 16'd1) begin
            n_err++;
            $display("FAIL single_count: got %0d, required 1", bus.wb_count_o);
        end
    endtask

    task automatic test_invalidate_clean();
        fill(1);
        run_walk();
        n_vec++;
        if (clr_log.size() != NL || clrv_viol != 0 || wb_log.size() != 0) begin
            n_err++;
            $display("FAIL clean_inv: clr %0d (clr_valid bad %0d) wb %0d, required %0d 0 0",
                     clr_log.size(), clrv_viol, wb_log.size(), NL);
        end
        n_vec++;
        if (bus.wb_count_o !== 16'd0) begin
            n_err++;
            $display("FAIL clean_count: got %0d, required 0", bus.wb_count_o);
        end
    endtask

    task automatic test_random();
        int bad_wb = 0, bad_clr = 0;
        fill(3);
        build_expected();
        run_walk();
        n_vec++;
        if (tag_log.size() != NL || order_errs() != 0) begin
            n_err++;
            $display("FAIL rand_tags: got %0d reads (%0d out of order), required %0d",
                     tag_log.size(), order_errs(), NL);
        end
        foreach (wb_log[k]) if (k >= exp_wb.size() || wb_log[k] !== exp_wb[k]) bad_wb++;
        n_vec++;
        if (wb_log.size() != exp_wb.size() || bad_wb != 0) begin
            n_err++;
            $display("FAIL rand_wb: got %0d wb (%0d wrong), required %0d", wb_log.size(),
                     bad_wb, exp_wb.size());
        end
        foreach (clr_log[k]) if (k >= exp_clr.size() || clr_log[k] != exp_clr[k]) bad_clr++;
        n_vec++;
        if (clr_log.size() != exp_clr.size() || bad_clr != 0) begin
            n_err++;
            $display("FAIL rand_clr: got %0d clr (%0d wrong), required %0d", clr_log.size(),
                     bad_clr, exp_clr.size());
        end
        n_vec++;
        if (bus.wb_count_o !== 16'(exp_count) || onehot_viol != 0 || ack_cnt != 1) begin
            n_err++;
            $display("FAIL rand_done: count %0d onehot %0d acks %0d, required %0d 0 1",
                     bus.wb_count_o, onehot_viol, ack_cnt, exp_count);
        end
    endtask

    task automatic test_backpressure();
        int ri = $urandom_range(0, NW - 1);
        int rw = $urandom_range(0, NA - 1);
        logic [PL-1:0] got;
        fill(0);
        m_valid[ri][rw] = 1'b1; m_dirty[ri][rw] = 1'b1;
        build_expected();
        gnt_stall = 7; done_dly = 4;
        run_walk();
        gnt_stall = 0; done_dly = 0;
        got = (wb_log.size() == 1) ? wb_log[0] : '1;
        n_vec++;
        if (wb_req_cycles != 8 || stable_viol != 0) begin
            n_err++;
            $display("FAIL bp_hold: req cycles %0d addr changes %0d, required 8 0",
                     wb_req_cycles, stable_viol);
        end
        n_vec++;
        if (wb_log.size() != 1 || got !== exp_wb[0] || bus.wb_count_o !== 16'd1) begin
            n_err++;
            $display("FAIL bp_wb: %0d wb addr %h count %0d, required 1 %h 1", wb_log.size(),
                     got, bus.wb_count_o, exp_wb[0]);
        end
        n_vec++;
        if (tag_log.size() != NL || order_errs() != 0) begin
            n_err++;
            $display("FAIL bp_order: got %0d reads (%0d out of order), required %0d",
                     tag_log.size(), order_errs(), NL);
        end
    endtask

    task automatic test_flush_while_busy();
        int c = 0;
        fill(0);
        clear_logs();
        bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
        while (!(bus.busy_o && bus.idx_o == 8'h20) && c < Budget) begin tick(); c++; end
        bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
        for (int k = 0; k < Budget && ack_cnt == 0; k++) tick();
        repeat (4) tick();
        n_vec++;
        if (c >= Budget || ack_cnt != 1 || tag_log.size() != NL || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL busy_flush: acks %0d reads %0d busy %b, required 1 %0d 0", ack_cnt,
                     tag_log.size(), bus.busy_o, NL);
        end
    endtask

    task automatic test_all_dirty();
        fill(2);
        run_walk();
        n_vec++;
        if (bus.wb_count_o !== 16'd2048 || wb_log.size() != NL || clr_log.size() != NL) begin
            n_err++;
            $display("FAIL dirty_all: count %0d wb %0d clr %0d, required 2048 each",
                     bus.wb_count_o, wb_log.size(), clr_log.size());
        end
        n_vec++;
        if (onehot_viol != 0) begin
            n_err++;
            $display("FAIL dirty_onehot: got %0d overlaps, required 0", onehot_viol);
        end
    endtask

    task automatic test_reset_mid_walk();
        int c = 0;
        int first;
        fill(0);
        clear_logs();
        bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
        while (!(bus.busy_o && bus.idx_o == 8'h40) && c < Budget) begin tick(); c++; end
        n_vec++;
        if (c >= Budget || bus.wb_count_o !== 16'd2048) begin
            n_err++;
            $display("FAIL mid_hold: count %0d while walking, required 2048", bus.wb_count_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.busy_o, bus.flush_ack_o, bus.tag_req_o, bus.wb_req_o, bus.clr_req_o,
             bus.idx_o, bus.way_o, bus.wb_count_o} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: busy %b reqs %b%b%b idx %h count %0d, required all 0",
                     bus.busy_o, bus.tag_req_o, bus.wb_req_o, bus.clr_req_o, bus.idx_o,
                     bus.wb_count_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
        for (int k = 0; k < 20 && tag_log.size() == 0; k++) tick();
        first = (tag_log.size() > 0) ? tag_log[0] : -1;
        n_vec++;
        if (first != 0) begin
            n_err++;
            $display("FAIL mid_restart: first read at line %0d, required 0", first);
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_back_to_back();
        int last;
        fill(0);
        clear_logs();
        bus.flush_i = 1'b1;
        for (int k = 0; k < Budget && ack_cnt == 0; k++) tick();
        tick();
        n_vec++;
        if (ack_cnt != 1 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: acks %0d busy %b, required 1 0", ack_cnt, bus.busy_o);
        end
        tick();
        bus.flush_i = 1'b0;
        last = (tag_log.size() > 0) ? tag_log[tag_log.size() - 1] : -1;
        n_vec++;
        if (bus.busy_o !== 1'b1 || tag_log.size() != NL + 1 || last != 0) begin
            n_err++;
            $display("FAIL b2b_restart: busy %b reads %0d last %0d, required 1 %0d 0",
                     bus.busy_o, tag_log.size(), last, NL + 1);
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    endtask

    task automatic small_walk(input bit dirty);
        foreach (s_valid[i, w]) begin s_valid[i][w] = 1'b1; s_dirty[i][w] = dirty; end
        s_tag_cnt = 0; s_wb_cnt = 0; s_clr_cnt = 0; s_ack_cnt = 0; s_order_err = 0;
        sbus.flush_i = 1'b1; tick(); sbus.flush_i = 1'b0;
        for (int k = 0; k < 200 && s_ack_cnt == 0; k++) tick();
        tick();
    endtask

    task automatic test_small_saturation();
        small_walk(1'b1);
        n_vec++;
        if (sbus.wb_count_o !== 16'd5 || s_wb_cnt != 8 || s_ack_cnt != 1) begin
            n_err++;
            $display("FAIL sat_count: count %0d wb %0d acks %0d, required 5 8 1",
                     sbus.wb_count_o, s_wb_cnt, s_ack_cnt);
        end
        n_vec++;
        if (s_tag_cnt != 8 || s_order_err != 0 || s_clr_cnt != 8) begin
            n_err++;
            $display("FAIL sat_walk: reads %0d order errs %0d clr %0d, required 8 0 8",
                     s_tag_cnt, s_order_err, s_clr_cnt);
        end
        small_walk(1'b0);
        n_vec++;
        if (s_clr_cnt != 0 || s_wb_cnt != 0 || sbus.wb_count_o !== 16'd0 ||
            sbus.clr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL noinv_clean: clr %0d wb %0d count %0d clr_valid %b, required 0 0 0 0",
                     s_clr_cnt, s_wb_cnt, sbus.wb_count_o, sbus.clr_valid_o);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_empty();
        test_single_dirty();
        test_invalidate_clean();
        test_random();
        test_backpressure();
        test_flush_while_busy();
        test_all_dirty();
        test_reset_mid_walk();
        test_back_to_back();
        test_small_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dcache_flush_walker.md
Name: dcache_flush_walker

Overview:
- Sequential flush engine between the cache controller's fence/flush request and the D-cache tag array and writeback port.
- Sized entirely by the derived `cva6_cfg_t`: `DCACHE_NUM_WORDS`, `DCACHE_SET_ASSOC`, `DCACHE_TAG_WIDTH`, `DcacheInvalidateOnFlush`.
- On request, walks every (index, way) pair, writes back dirty lines, clears state bits, then acknowledges.
- Used by `fence` when `DcacheFlushOnFence` is set.

Parameters:
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`, derived core configuration. Width aliases used below:
  - `IDX_W = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH`
  - `WAY_W = DCACHE_SET_ASSOC_WIDTH`
  - `TAG_W = DCACHE_TAG_WIDTH`

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: flush request, level or pulse; sampled only in IDLE.
- `busy_o` out 1: walk in progress.
- `flush_ack_o` out 1: one-cycle pulse on completion.
- `tag_req_o` out 1: tag-array read request.
- `tag_gnt_i` in 1: tag read accepted.
- `tag_rvalid_i` in 1: tag read data valid.
- `tag_valid_i` in 1: line valid bit.
- `tag_dirty_i` in 1: line dirty bit.
- `tag_i` in TAG_W: line tag.
- `idx_o` out IDX_W: current index.
- `way_o` out WAY_W: current way.
- `wb_req_o` out 1: writeback request.
- `wb_gnt_i` in 1: writeback accepted.
- `wb_done_i` in 1: writeback completed.
- `wb_addr_o` out PLEN: line address = `{tag_q, idx_q, DCACHE_OFFSET_WIDTH'0}`.
- `clr_req_o` out 1: state-bit clear write.
- `clr_gnt_i` in 1: clear accepted.
- `clr_valid_o` out 1: also clear valid; equals `DcacheInvalidateOnFlush`, constant.
- `wb_count_o` out 16: dirty lines written back in the last walk, saturating.

Behaviour:
- Reset: FSM=IDLE; `idx_q`, `way_q`, `tag_q` = 0; all `*_req_o`, `busy_o`, `flush_ack_o` = 0; `wb_count_o` = 0.
- States: IDLE, TAG_REQ, TAG_WAIT, WB_REQ, WB_WAIT, CLR_REQ, NEXT, DONE.
- IDLE: on `flush_i`=1, clear `idx_q`, `way_q` and the walk counter, then go to TAG_REQ.
- TAG_REQ: assert `tag_req_o`. Hold `idx_o`/`way_o` stable until `tag_gnt_i`, then go to TAG_WAIT.
- TAG_WAIT: wait for `tag_rvalid_i`. On it, capture `tag_i` into `tag_q` and branch:
  - valid & dirty → WB_REQ.
  - valid & !dirty & `DcacheInvalidateOnFlush` → CLR_REQ.
  - otherwise → NEXT.
- WB_REQ: assert `wb_req_o` with `wb_addr_o` stable until `wb_gnt_i`, then go to WB_WAIT.
- WB_WAIT: wait for `wb_done_i`. Increment the counter (saturate at 0xFFFF), then go to CLR_REQ.
  - `wb_done_i` arriving in the same cycle as `wb_gnt_i` is legal: counted, go straight to CLR_REQ.
- CLR_REQ: assert `clr_req_o` until `clr_gnt_i`. The write always clears dirty; it also clears valid iff `clr_valid_o`. Then go to NEXT.
- NEXT: way increments first, index second.
  - If `way_q == DCACHE_SET_ASSOC-1`: `way_q`←0 and `idx_q`++.
  - When `idx_q == DCACHE_NUM_WORDS-1` and the last way is done → DONE; otherwise → TAG_REQ.
  - `DCACHE_SET_ASSOC == 1`: `way_q` stays 0.
- DONE: `flush_ack_o`=1 for exactly one cycle. `wb_count_o` updated from the walk counter in the same cycle. Then go to IDLE.
- Outputs:
  - `busy_o`=1 in every state except IDLE.
  - `wb_count_o` holds its value until the next DONE.
- Handshake rules:
  - Requests are level-held until their grant and deasserted the cycle after the grant.
  - Never more than one of `tag_req_o`/`wb_req_o`/`clr_req_o` asserted.
- Boundary conditions:
  - `flush_i` while busy: ignored, no queuing.
  - `flush_i` held high across DONE: a new walk starts the cycle after return to IDLE.
  - Reset mid-walk: immediate return to IDLE with all outputs at reset values; a partially completed walk is not resumed.
- Cycle budget: minimal walk time with all lines invalid and zero-latency grants is 3 cycles per (index, way) (TAG_REQ, TAG_WAIT, NEXT), plus DONE.

Test Plan:
All scenarios use the default config: 8 ways, `IDX_W`=8 (256 sets), PLEN=56, TAG_W=44, grants same-cycle, `tag_rvalid_i` one cycle after grant.
- Empty cache (all invalid), `flush_i` pulse → exactly 2048 tag reads, 0 `wb_req_o`, 0 `clr_req_o`, `flush_ack_o` pulse, `wb_count_o`=0, `busy_o` falls after ack.
- Single dirty line at idx=0x5A way=3, tag=0xABC → one `wb_req_o` with `wb_addr_o`=0x0000ABC5A0 (tag<<12 | 0x5A<<4), then one `clr_req_o` at idx 0x5A way 3; `wb_count_o`=1.
- `DcacheInvalidateOnFlush`=1, every line valid & clean → 2048 `clr_req_o` with `clr_valid_o`=1, 0 writebacks. Same with `DcacheInvalidateOnFlush`=0 → 0 clears.
- Back-pressure: hold `wb_gnt_i`=0 for 7 cycles, then assert `wb_done_i` 4 cycles after grant → `wb_req_o`/`wb_addr_o` stable throughout, counter increments once, walk order unchanged.
- `flush_i` re-asserted at idx 0x20 mid-walk → ignored, single ack; `rst_ni` low at idx 0x40 → all outputs 0 asynchronously, IDLE, next `flush_i` restarts at idx 0 way 0.
- All 2048 lines dirty with a 16-bit count check → `wb_count_o`=2048; forced-saturation variant with the counter preloaded near max → holds 0xFFFF.
